// File: rtl/neuron_seq.sv
// Sequencer that streams one input vector through a serial neuron.
// Holds weights/bias, pulses clear, feeds N_IN inputs, samples result.
module neuron_seq #(
  parameter int N_IN = 8,
  parameter int LAT  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [$clog2(N_IN)-1:0] cfg_addr,
  input  logic [7:0]              cfg_w,
  input  logic                    cfg_sw,
  input  logic                    cfg_bias_we,
  input  logic [7:0]              cfg_bias,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [N_IN-1:0]         x_spk,
  input  logic [N_IN-1:0]         x_sign,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [7:0]              y_data,
  output logic                    busy,
  output logic                    n_clr,
  output logic                    n_tac,
  output logic                    n_sign_x,
  output logic                    n_sign_w,
  output logic [7:0]              n_win,
  output logic [7:0]              n_bias,
  input  logic [7:0]              n_dout
);

  localparam int IW = $clog2(N_IN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_WAIT,
    S_OUT
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   idx_q;
  logic [2:0]      wc_q;
  logic [7:0]      w_q [N_IN];
  logic [N_IN-1:0] sw_q;
  logic [N_IN-1:0] spk_q;
  logic [N_IN-1:0] sgn_q;
  logic [7:0]      bias_q;
  logic [7:0]      y_q;
  logic            idle;
  logic            last_idx;
  logic            wait_end;
  logic            addr_ok;

  assign idle     = (state_q == S_IDLE);
  assign last_idx = (idx_q == IW'(N_IN - 1));
  // The neuron registers the last input at the end of RUN, then
  // needs LAT more cycles; sampling happens on the edge after that.
  assign wait_end = (wc_q == 3'(LAT));
  assign addr_ok  = (32'(cfg_addr) < 32'(N_IN));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d  = state_q;
    x_ready  = 1'b0;
    y_valid  = 1'b0;
    busy     = 1'b1;
    n_clr    = 1'b0;
    n_tac    = 1'b0;
    n_sign_x = 1'b0;
    n_sign_w = 1'b0;
    n_win    = 8'd0;
    unique case (state_q)
      S_IDLE: begin
        x_ready = 1'b1;
        busy    = 1'b0;
        if (x_valid) state_d = S_CLR;
      end
      S_CLR: begin
        n_clr   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        n_tac    = spk_q[idx_q];
        n_sign_x = sgn_q[idx_q];
        n_sign_w = sw_q[idx_q];
        n_win    = w_q[idx_q];
        if (last_idx) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_end) state_d = S_OUT;
      end
      S_OUT: begin
        y_valid = 1'b1;
        if (y_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign y_data = y_q;
  assign n_bias = bias_q;

  // Sequencing counters, latched vector and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      wc_q  <= '0;
      spk_q <= '0;
      sgn_q <= '0;
      y_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (x_valid) begin
            spk_q <= x_spk;
            sgn_q <= x_sign;
          end
        end
        S_CLR: begin
          idx_q <= '0;
        end
        S_RUN: begin
          idx_q <= idx_q + 1'b1;
          wc_q  <= '0;
        end
        S_WAIT: begin
          wc_q <= wc_q + 1'b1;
          if (wait_end) y_q <= n_dout;
        end
        default: ;
      endcase
    end
  end

  // Weight and bias tables, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) w_q[k] <= '0;
      sw_q   <= '0;
      bias_q <= '0;
    end else if (idle) begin
      if (cfg_we && addr_ok) begin
        w_q[cfg_addr]  <= cfg_w;
        sw_q[cfg_addr] <= cfg_sw;
      end
      if (cfg_bias_we) bias_q <= cfg_bias;
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq: directed vectors, queued expectations,
// and a negedge monitor that checks RUN cycles and results.
module tb_neuron_seq;

  localparam int N_IN = 8;
  localparam int LAT  = 2;

  typedef struct {
    logic       tac;
    logic       sx;
    logic       sw;
    logic [7:0] win;
  } run_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_w = '0;
  logic       cfg_sw = 1'b0;
  logic       cfg_bias_we = 1'b0;
  logic [7:0] cfg_bias = '0;
  logic       x_valid = 1'b0;
  logic       x_ready;
  logic [7:0] x_spk = '0;
  logic [7:0] x_sign = '0;
  logic       y_valid;
  logic       y_ready = 1'b1;
  logic [7:0] y_data;
  logic       busy;
  logic       n_clr;
  logic       n_tac;
  logic       n_sign_x;
  logic       n_sign_w;
  logic [7:0] n_win;
  logic [7:0] n_bias;
  logic [7:0] n_dout;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] tb_w [N_IN];
  logic [7:0] tb_sw;

  run_t       run_q [$];
  logic [7:0] exp_q [$];
  int         xfer_q [$];

  logic [7:0] acc = '0;

  neuron_seq #(.N_IN(N_IN), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_w(cfg_w), .cfg_sw(cfg_sw),
    .cfg_bias_we(cfg_bias_we), .cfg_bias(cfg_bias),
    .x_valid(x_valid), .x_ready(x_ready),
    .x_spk(x_spk), .x_sign(x_sign),
    .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data), .busy(busy),
    .n_clr(n_clr), .n_tac(n_tac),
    .n_sign_x(n_sign_x), .n_sign_w(n_sign_w),
    .n_win(n_win), .n_bias(n_bias),
    .n_dout(n_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple serial neuron: signed accumulate of weights on each tac.
  always @(posedge clk) begin
    if (n_clr) acc <= n_bias;
    else if (n_tac)
      acc <= (n_sign_x ^ n_sign_w) ? acc - n_win : acc + n_win;
  end
  assign n_dout = acc;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor.
  bit         clr_prev = 0;
  bit         prev_yv = 0;
  bit         post_hs = 0;
  int         rc = 0;
  logic [7:0] cur_y = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rc = 0;
      clr_prev = 0;
      prev_yv = 0;
      post_hs = 0;
      xfer_q.delete();
      run_q.delete();
    end else begin
      if (x_valid && x_ready) xfer_q.push_back(cyc + 1);
      if (post_hs) begin
        chk(!y_valid && x_ready, "idle_after_out",
            {y_valid, x_ready}, 1);
        post_hs = 0;
      end
      if (n_clr) begin
        chk(!clr_prev, "clr_width", 2, 1);
        rc = N_IN;
      end else if (rc > 0) begin
        if (run_q.size() == 0) begin
          chk(0, "run_unexpected", 1, 0);
        end else begin
          run_t e;
          e = run_q.pop_front();
          chk(n_tac == e.tac, "run_tac", n_tac, e.tac);
          chk(n_sign_x == e.sx, "run_sign_x", n_sign_x, e.sx);
          chk(n_sign_w == e.sw, "run_sign_w", n_sign_w, e.sw);
          chk(n_win == e.win, "run_win", n_win, e.win);
        end
        rc--;
      end else if (busy) begin
        chk(!n_tac && n_win == 0 && !n_sign_x && !n_sign_w,
            "idle_neuron_in", {n_tac, n_win}, 0);
      end
      clr_prev = n_clr;
      if (y_valid) begin
        if (!prev_yv) begin
          if (exp_q.size() == 0 || xfer_q.size() == 0) begin
            chk(0, "y_unexpected", y_data, 0);
          end else begin
            int t;
            cur_y = exp_q.pop_front();
            t = xfer_q.pop_front();
            chk(y_data == cur_y, "y_data", y_data, cur_y);
            chk(cyc - t == N_IN + LAT + 2, "latency",
                cyc - t, N_IN + LAT + 2);
          end
        end else begin
          chk(y_data == cur_y, "y_hold", y_data, cur_y);
        end
        chk(!x_ready && busy, "ready_in_out", x_ready, 0);
        if (y_ready) post_hs = 1;
      end
      prev_yv = y_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wcfg(input int a, input logic [7:0] w,
                      input logic s);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_w = w;
    cfg_sw = s;
    tb_w[a] = w;
    tb_sw[a] = s;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] spk, input logic [7:0] sg,
                      input logic [7:0] ey, input int nrun,
                      input bit push_y);
    int k = 0;
    while (!x_ready && k < 100) begin
      step();
      k++;
    end
    if (!x_ready) chk(0, "x_ready_timeout", 0, 1);
    for (int i = 0; i < nrun; i++) begin
      run_t r;
      r.tac = spk[i];
      r.sx = sg[i];
      r.sw = tb_sw[i];
      r.win = tb_w[i];
      run_q.push_back(r);
    end
    if (push_y) exp_q.push_back(ey);
    x_spk = spk;
    x_sign = sg;
    x_valid = 1'b1;
    step();
    x_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((busy || y_valid) && k < 200) begin
      step();
      k++;
    end
    if (busy) chk(0, "done_timeout", 1, 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < N_IN; i++) tb_w[i] = '0;
    tb_sw = '0;
    #1;
    chk(x_ready && !busy && !y_valid && !n_clr && !n_tac,
        "reset_ctrl", {x_ready, busy, y_valid, n_clr, n_tac}, 16);
    chk(y_data == 0 && n_bias == 0 && n_win == 0,
        "reset_data", y_data, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk(x_ready && !busy, "post_reset_ready", x_ready, 1);

    // Weights 10..80 positive, bias 5.
    for (int i = 0; i < N_IN; i++) wcfg(i, 8'(10 * (i + 1)), 1'b0);
    cfg_bias_we = 1'b1;
    cfg_bias = 8'd5;
    step();
    cfg_bias_we = 1'b0;
    chk(n_bias == 8'd5, "bias_out", n_bias, 5);

    // All spikes: 360 + 5 = 365 -> 109.
    send(8'hFF, 8'h00, 8'd109, N_IN, 1);
    wait_done();

    // No spikes: bias only.
    send(8'h00, 8'h00, 8'd5, N_IN, 1);
    wait_done();

    // Back-pressure: hold y_ready low for 5 cycles.
    y_ready = 1'b0;
    send(8'hFF, 8'h00, 8'd109, N_IN, 1);
    for (int k = 0; k < 100 && !y_valid; k++) step();
    repeat (5) step();
    y_ready = 1'b1;
    wait_done();

    // Config write while busy must be dropped.
    send(8'hFF, 8'h00, 8'd109, N_IN, 1);
    for (int k = 0; k < 100 && !busy; k++) step();
    step();
    cfg_we = 1'b1;
    cfg_addr = 3'd3;
    cfg_w = 8'd200;
    cfg_sw = 1'b1;
    step();
    cfg_we = 1'b0;
    wait_done();
    send(8'hFF, 8'h00, 8'd109, N_IN, 1);
    wait_done();

    // Mixed signs: sw[i]=1 for odd i; entry 7 written on the
    // transfer edge. -10-30-60-80+5 = -175 -> 81.
    for (int i = 0; i < N_IN - 1; i++)
      wcfg(i, 8'(10 * (i + 1)), 1'(i % 2));
    cfg_we = 1'b1;
    cfg_addr = 3'd7;
    cfg_w = 8'd80;
    cfg_sw = 1'b1;
    tb_w[7] = 8'd80;
    tb_sw[7] = 1'b1;
    send(8'hA5, 8'h0F, 8'd81, N_IN, 1);
    cfg_we = 1'b0;
    wait_done();

    // Abort at RUN i=4 via reset.
    send(8'hFF, 8'h00, 8'd0, 4, 0);
    for (int k = 0; k < 20 && !n_clr; k++) @(negedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk(!busy && !y_valid && !n_clr && !n_tac && x_ready,
        "abort_ctrl", {busy, y_valid, n_clr, n_tac}, 0);
    chk(n_win == 0 && n_bias == 0 && y_data == 0,
        "abort_data", n_win, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N_IN; i++) tb_w[i] = '0;
    tb_sw = '0;
    step();
    send(8'hFF, 8'h00, 8'd0, N_IN, 1);
    wait_done();

    repeat (3) step();
    chk(exp_q.size() == 0, "exp_left", exp_q.size(), 0);
    chk(run_q.size() == 0, "run_left", run_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
